// File: rtl/myrsp_packetizer_mb.sv
// myRSP packetizer, multi-byte input: serialises pixel beats into byte packets
// framed as {6-byte header, payload, 1-byte flags trailer}, then presents a
// length descriptor for the UDP encapsulation stage.
module myrsp_packetizer_mb #(
  parameter int unsigned PIX_BYTES   = 2,
  parameter int unsigned MAX_PAYLOAD = 1400
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*PIX_BYTES-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   m_axis_hdr_valid,
  input  logic                   m_axis_hdr_ready,
  output logic [15:0]            m_axis_hdr_length
);

  localparam int unsigned BEAT_W    = 8 * PIX_BYTES;
  localparam int unsigned LANE_W    = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
  localparam int unsigned HDR_BYTES = 6;
  localparam int unsigned FRAME_OVH = 7;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_BYTES - 1);
  localparam logic [15:0]       MAX_PL    = 16'(MAX_PAYLOAD);
  localparam logic [2:0]        HDR_LAST  = 3'(HDR_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    TRAILER = 3'd3,
    LEN     = 3'd4
  } state_t;

  state_t state;

  logic [15:0]       scene;
  logic [15:0]       row;
  logic [15:0]       col;
  logic [15:0]       payload_cnt;
  logic [39:0]       hdr_sr;
  logic [2:0]        hdr_cnt;
  logic              sos;
  logic              flag_eol;
  logic              flag_eos;
  logic [BEAT_W-1:0] hold_data;
  logic              hold_full;
  logic              hold_last;
  logic              hold_user;
  logic [LANE_W-1:0] lane;
  logic              out_free;

  // Output byte register can take a new byte when empty or being consumed
  assign out_free = !m_axis_tvalid || m_axis_tready;

  // Packet framing FSM with registered stream, descriptor and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      scene             <= '0;
      row               <= '0;
      col               <= '0;
      payload_cnt       <= '0;
      hdr_sr            <= '0;
      hdr_cnt           <= '0;
      sos               <= 1'b0;
      flag_eol          <= 1'b0;
      flag_eos          <= 1'b0;
      hold_data         <= '0;
      hold_full         <= 1'b0;
      hold_last         <= 1'b0;
      hold_user         <= 1'b0;
      lane              <= '0;
      s_axis_tready     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser      <= 1'b0;
      m_axis_hdr_valid  <= 1'b0;
      m_axis_hdr_length <= '0;
    end else begin
      case (state)
        // A pending beat opens a packet: latch header fields, emit byte 0
        IDLE: begin
          if (s_axis_tvalid) begin
            sos           <= (row == 16'd0) && (col == 16'd0);
            hdr_sr        <= {col, row, scene[15:8]};
            hdr_cnt       <= 3'd1;
            m_axis_tdata  <= scene[7:0];
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= (row == 16'd0) && (col == 16'd0);
            state         <= HEADER;
          end
        end

        // Shift out the remaining header bytes, one per handshake
        HEADER: begin
          if (m_axis_tready) begin
            m_axis_tuser <= 1'b0;
            if (hdr_cnt == HDR_LAST) begin
              m_axis_tvalid <= 1'b0;
              s_axis_tready <= 1'b1;
              state         <= PAYLOAD;
            end else begin
              m_axis_tdata <= hdr_sr[7:0];
              hdr_sr       <= hdr_sr >> 8;
              hdr_cnt      <= hdr_cnt + 3'd1;
            end
          end
        end

        // Fill the holding register and drain it lane 0 first
        PAYLOAD: begin
          if (s_axis_tvalid && s_axis_tready) begin
            hold_data     <= s_axis_tdata;
            hold_full     <= 1'b1;
            hold_last     <= s_axis_tlast;
            hold_user     <= s_axis_tuser;
            lane          <= '0;
            s_axis_tready <= 1'b0;
          end
          if (out_free) begin
            if (hold_full) begin
              m_axis_tdata  <= 8'(hold_data >> {lane, 3'b000});
              m_axis_tvalid <= 1'b1;
              payload_cnt   <= payload_cnt + 16'd1;
              if (lane == LAST_LANE) begin
                hold_full <= 1'b0;
                lane      <= '0;
                if (hold_last || hold_user || (payload_cnt + 16'd1 == MAX_PL)) begin
                  flag_eol <= hold_last || hold_user;
                  flag_eos <= hold_user;
                  state    <= TRAILER;
                end else begin
                  s_axis_tready <= 1'b1;
                end
              end else begin
                lane <= lane + LANE_W'(1);
              end
            end else begin
              m_axis_tvalid <= 1'b0;
            end
          end
        end

        // Emit the flags byte; its handshake closes the packet and moves counters
        TRAILER: begin
          if (m_axis_tvalid && m_axis_tlast) begin
            if (m_axis_tready) begin
              m_axis_tvalid     <= 1'b0;
              m_axis_tlast      <= 1'b0;
              m_axis_hdr_valid  <= 1'b1;
              m_axis_hdr_length <= payload_cnt + 16'(FRAME_OVH);
              state             <= LEN;
              if (flag_eos) begin
                scene <= scene + 16'd1;
                row   <= '0;
                col   <= '0;
              end else if (flag_eol) begin
                row <= row + 16'd1;
                col <= '0;
              end else begin
                col <= col + payload_cnt;
              end
            end
          end else if (out_free) begin
            m_axis_tdata  <= {5'b00000, sos, flag_eos, flag_eol};
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b1;
          end
        end

        // Hold the length descriptor until the UDP stage takes it
        LEN: begin
          if (m_axis_hdr_ready) begin
            m_axis_hdr_valid <= 1'b0;
            payload_cnt      <= '0;
            state            <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_myrsp_packetizer_mb.sv
// Self-checking bench for myrsp_packetizer_mb (PIX_BYTES=2, MAX_PAYLOAD=8).
`timescale 1ns/1ps
module tb_myrsp_packetizer_mb;

  localparam int unsigned PB   = 2;
  localparam int unsigned MAXP = 8;

  typedef struct packed { logic [15:0] d; logic last; logic user; } beat_t;
  typedef struct packed { logic [7:0] d; logic last; logic user; } obyte_t;
  typedef struct { int nbeats; logic lst; logic usr; int exp_pkts; int exp_len; } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_hdr_valid;
  logic        m_axis_hdr_ready;
  logic [15:0] m_axis_hdr_length;

  beat_t       src_q[$];
  obyte_t      exp_q[$];
  logic [15:0] len_q[$];

  int          checks     = 0;
  int          failures   = 0;
  int          out_bytes  = 0;
  int          pkt_cnt    = 0;
  logic [15:0] last_len   = '0;
  logic        s_hs       = 1'b0;
  logic        rdy_in_len = 1'b0;
  logic        rand_rdy   = 1'b0;
  int          hdr_delay  = 0;
  int          hdr_wait   = 0;
  logic [15:0] m_scene    = '0;
  logic [15:0] m_row      = '0;
  logic [15:0] m_col      = '0;

  always #5 clk = ~clk;

  myrsp_packetizer_mb #(.PIX_BYTES(PB), .MAX_PAYLOAD(MAXP)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tuser      (s_axis_tuser),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_hdr_valid  (m_axis_hdr_valid),
    .m_axis_hdr_ready  (m_axis_hdr_ready),
    .m_axis_hdr_length (m_axis_hdr_length)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic last, input logic user);
    obyte_t o;
    o.d    = d;
    o.last = last;
    o.user = user;
    exp_q.push_back(o);
  endtask

  // Reference packetizer: one line of beats -> expected bytes and lengths
  task automatic model_line(input int nb, input logic lst, input logic usr, input logic [7:0] base);
    int          total;
    int          off;
    int          n;
    logic        fin;
    logic        sos;
    logic        eol;
    logic        eos;
    logic [15:0] w;
    beat_t       b;
    total = nb * PB;
    off   = 0;
    while (off < total) begin
      n   = (total - off > MAXP) ? MAXP : total - off;
      fin = (off + n == total);
      sos = (m_row == 16'd0) && (m_col == 16'd0);
      eol = fin && (lst || usr);
      eos = fin && usr;
      for (int k = 0; k < 6; k++) begin
        w = (k < 2) ? m_scene : (k < 4) ? m_row : m_col;
        push_exp((k % 2 == 1) ? w[15:8] : w[7:0], 1'b0, (k == 0) && sos);
      end
      for (int k = 0; k < n; k++) push_exp(8'(base + 8'(off + k)), 1'b0, 1'b0);
      push_exp({5'b00000, sos, eos, eol}, 1'b1, 1'b0);
      len_q.push_back(16'(n + 7));
      if (eos) begin
        m_scene = m_scene + 16'd1;
        m_row   = '0;
        m_col   = '0;
      end else if (eol) begin
        m_row = m_row + 16'd1;
        m_col = '0;
      end else begin
        m_col = m_col + 16'(n);
      end
      off = off + n;
    end
    for (int i = 0; i < nb; i++) begin
      b.d    = {8'(base + 8'(2 * i + 1)), 8'(base + 8'(2 * i))};
      b.last = (i == nb - 1) && lst;
      b.user = (i == nb - 1) && usr;
      src_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || len_q.size() != 0 || src_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size() + len_q.size() + src_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tdata"}, 32'(m_axis_tdata), 32'd0);
    chk({tag, "_tlast_tuser"}, 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
    chk({tag, "_hdr_valid"}, 32'(m_axis_hdr_valid), 32'd0);
    chk({tag, "_hdr_length"}, 32'(m_axis_hdr_length), 32'd0);
    chk({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
  endtask

  // Input driver and ready generators, updated just after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (s_hs && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src_q[0].d;
      s_axis_tlast  = src_q[0].last;
      s_axis_tuser  = src_q[0].user;
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
    end
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (m_axis_hdr_valid && !m_axis_hdr_ready) begin
      if (hdr_wait >= hdr_delay) m_axis_hdr_ready = 1'b1;
      else hdr_wait++;
    end else begin
      m_axis_hdr_ready = (hdr_delay == 0);
      hdr_wait         = 0;
    end
  end

  // Scoreboard: compare every byte and descriptor handshake against the queues
  always @(negedge clk) begin
    obyte_t e;
    s_hs = s_axis_tvalid && s_axis_tready && !rst;
    if (!rst) begin
      if (m_axis_hdr_valid && s_axis_tready) rdy_in_len = 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        out_bytes++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_byte", 32'({m_axis_tlast, m_axis_tuser, m_axis_tdata}));
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("byte%0d", out_bytes), 32'({m_axis_tlast, m_axis_tuser, m_axis_tdata}),
              32'({e.last, e.user, e.d}));
        end
      end
      if (m_axis_hdr_valid && m_axis_hdr_ready) begin
        pkt_cnt++;
        last_len = m_axis_hdr_length;
        if (len_q.size() == 0) fail_now("unexpected_desc", 32'(m_axis_hdr_length));
        else chk($sformatf("desc%0d", pkt_cnt), 32'(m_axis_hdr_length), 32'(len_q.pop_front()));
      end
    end
  end

  initial begin
    vec_t        vecs [7];
    logic [7:0]  t1 [13];
    beat_t       b;
    int          p0;
    int          ob0;
    int          n;

    vecs[0] = '{nbeats: 6, lst: 1'b1, usr: 1'b0, exp_pkts: 2, exp_len: 11};
    vecs[1] = '{nbeats: 4, lst: 1'b1, usr: 1'b0, exp_pkts: 1, exp_len: 15};
    vecs[2] = '{nbeats: 1, lst: 1'b1, usr: 1'b1, exp_pkts: 1, exp_len: 9};
    vecs[3] = '{nbeats: 3, lst: 1'b1, usr: 1'b0, exp_pkts: 1, exp_len: 13};
    vecs[4] = '{nbeats: 2, lst: 1'b0, usr: 1'b1, exp_pkts: 1, exp_len: 11};
    vecs[5] = '{nbeats: 9, lst: 1'b1, usr: 1'b0, exp_pkts: 3, exp_len: 9};
    vecs[6] = '{nbeats: 5, lst: 1'b1, usr: 1'b0, exp_pkts: 2, exp_len: 9};

    t1 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h05, 8'h00};
    t1[6]  = 8'h00;
    t1[7]  = 8'h11;
    t1[8]  = 8'h22;
    t1[9]  = 8'h33;
    t1[10] = 8'h44;
    t1[11] = 8'h55;
    t1[12] = 8'h05;

    rst              = 1'b1;
    s_axis_tvalid    = 1'b0;
    s_axis_tdata     = '0;
    s_axis_tlast     = 1'b0;
    s_axis_tuser     = 1'b0;
    m_axis_tready    = 1'b1;
    m_axis_hdr_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Hand-written first line: 0x1100, 0x3322, 0x5544 with tlast on the third
    b = '{d: 16'h1100, last: 1'b0, user: 1'b0}; src_q.push_back(b);
    b = '{d: 16'h3322, last: 1'b0, user: 1'b0}; src_q.push_back(b);
    b = '{d: 16'h5544, last: 1'b1, user: 1'b0}; src_q.push_back(b);
    for (int k = 0; k < 13; k++) push_exp(t1[k], k == 12, k == 0);
    len_q.push_back(16'd13);
    m_row = 16'd1;
    p0 = pkt_cnt;
    wait_drain(500);
    chk("line1_pkts", 32'(pkt_cnt - p0), 32'd1);
    chk("line1_len", 32'(last_len), 32'd13);

    // Vector table, first without stalls, then with random ready and slow descriptor ready
    for (int pass = 0; pass < 2; pass++) begin
      rand_rdy  = (pass == 1);
      hdr_delay = (pass == 1) ? 20 : 0;
      for (int i = 0; i < 7; i++) begin
        p0 = pkt_cnt;
        model_line(vecs[i].nbeats, vecs[i].lst, vecs[i].usr, 8'(8'h20 * i + 8'h08 * pass));
        wait_drain(3000);
        chk($sformatf("vec%0d_p%0d_pkts", i, pass), 32'(pkt_cnt - p0), 32'(vecs[i].exp_pkts));
        chk($sformatf("vec%0d_p%0d_len", i, pass), 32'(last_len), 32'(vecs[i].exp_len));
      end
    end
    rand_rdy  = 1'b0;
    hdr_delay = 0;
    repeat (2) @(posedge clk);
    #2;

    // Row wrap: jump the idle row counter to 0xFFFF instead of streaming 65535 lines
    @(negedge clk);
    force dut.row = 16'hFFFF;
    @(posedge clk);
    #2;
    release dut.row;
    m_row = 16'hFFFF;
    m_col = 16'd0;
    model_line(1, 1'b1, 1'b0, 8'hA0);
    wait_drain(500);
    p0 = pkt_cnt;
    model_line(1, 1'b1, 1'b0, 8'hB0);
    wait_drain(500);
    chk("wrap_pkts", 32'(pkt_cnt - p0), 32'd1);
    chk("wrap_len", 32'(last_len), 32'd9);

    // Reset in the middle of a payload
    ob0 = out_bytes;
    p0  = pkt_cnt;
    model_line(6, 1'b1, 1'b0, 8'h40);
    n = 0;
    while (out_bytes < ob0 + 8 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("reach_payload", 32'(out_bytes >= ob0 + 8), 32'd1);
    rst = 1'b1;
    src_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midrst");
    exp_q.delete();
    len_q.delete();
    m_scene = '0;
    m_row   = '0;
    m_col   = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("midrst_no_desc", 32'(pkt_cnt - p0), 32'd0);
    p0 = pkt_cnt;
    model_line(1, 1'b1, 1'b0, 8'hC0);
    wait_drain(500);
    repeat (30) @(posedge clk);
    chk("post_rst_pkts", 32'(pkt_cnt - p0), 32'd1);
    chk("tready_in_len", 32'(rdy_in_len), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/myrsp_packetizer_mb.md
Name: myrsp_packetizer_mb

Overview:
- Second-generation myRSP packetizer. Accepts multi-byte pixel beats from the camera FIFO, serialises them to a byte stream and chops each line into packets of at most MAX_PAYLOAD bytes.
- Each packet is framed as a 6-byte header (scene, row, column byte offset), then the payload, then a 1-byte flags trailer.
- After each packet, a length descriptor is presented for the UDP encapsulation stage.
- Sits between the camera AXI-Stream FIFO and the UDP TX path.

Parameters:
- PIX_BYTES, 2, bytes per input beat (1..4); serialised least-significant byte first.
- MAX_PAYLOAD, 1400, maximum payload bytes per packet. Must be a multiple of PIX_BYTES and at most 65528.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_axis_tdata  in  8*PIX_BYTES  pixel beat
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last beat of line
- s_axis_tuser  in  1  last beat of scene (implies end of line)
- m_axis_tdata  out  8  packet byte
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  trailer byte (last byte of packet)
- m_axis_tuser  out  1  first header byte of the first packet of a scene
- m_axis_hdr_valid  out  1  length descriptor valid
- m_axis_hdr_ready  in  1  length descriptor ready
- m_axis_hdr_length  out  16  total packet bytes = 6 + payload + 1

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0. scene/row/col counters, payload counter and beat holding register are cleared; FSM goes to IDLE. A packet in flight is abandoned, with no descriptor issued.
- Outputs are registered. m_axis_tvalid, once high, holds tdata, tlast and tuser stable until m_axis_tready=1; the same rule applies to hdr_valid and hdr_length.
- IDLE:
  - On s_axis_tvalid=1, latch the header {scene, row, col} and go to HEADER.
  - The first header byte is valid the next cycle.
  - No packet starts without a pending input beat, so empty packets never occur.
- HEADER:
  - Six bytes in order: scene[7:0], scene[15:8], row[7:0], row[15:8], col[7:0], col[15:8].
  - Each byte advances on a tready handshake.
  - The sixth accepted byte moves the FSM to PAYLOAD.
- PAYLOAD:
  - s_axis_tready=1 only when the holding register is empty.
  - An accepted beat fills the register, capturing tlast and tuser.
  - Bytes are emitted lane 0 first. The register empties when lane PIX_BYTES-1 is accepted, and the beat's tready may re-assert in that same cycle (no bubble).
  - Each accepted byte increments the payload counter (16-bit).
  - When the final byte of a beat is accepted, go to TRAILER if any of these holds:
    - captured tuser=1;
    - captured tlast=1;
    - the payload counter reaches MAX_PAYLOAD.
  - Otherwise fetch the next beat.
- TRAILER:
  - Emit one flags byte with tlast=1. Bit0 = EOL (tlast or tuser). Bit1 = EOS (tuser). Bit2 = SOS (row==0 and col==0 at header latch). Bits 7:3 = 0.
  - On handshake, go to LEN.
  - At the same handshake, update the counters:
    - EOS: scene+1, row=0, col=0.
    - Otherwise EOL: row+1, col=0.
    - Otherwise (chop): col += payload.
- LEN:
  - hdr_valid=1, hdr_length = payload+7.
  - On hdr_ready, clear hdr_valid and the payload counter, then go to IDLE.
  - The next packet cannot start before the descriptor is accepted.
- Simultaneous events:
  - A chop limit coinciding with tlast is an EOL packet; row increments and col resets.
  - tuser without tlast is treated as EOL+EOS.
- Wrap-around: scene, row and col are 16-bit and wrap from 0xFFFF to 0 silently.
- m_axis_tuser=1 only on header byte 0 of a packet whose SOS flag will be set; 0 elsewhere.
- Backpressure: m_axis_tready=0 for any duration stalls the FSM with no data loss or duplication.

Test Plan:
- Line of 3 beats, PIX_BYTES=2, MAX_PAYLOAD=8, beats 0x1100, 0x3322, 0x5544 (tlast on the third), with m_axis_tready tied to 1 -> bytes 00 00 00 00 00 00 00 11 22 33 44 55 05, with tlast on the trailer byte and m_axis_tuser=1 on the first byte. Descriptor length = 13.
- Line of 6 beats, MAX_PAYLOAD=8 -> packet 1 has col=0, 8 payload bytes, flags 0x04, length 15. Packet 2 has col=8 (header bytes 08 00), 4 payload bytes, flags 0x01, length 11. Row then equals 1.
- Last beat of scene with tuser=1 and tlast=1 -> flags bit1 set. The next packet's header is scene=1, row=0, col=0, and m_axis_tuser=1 on its first byte.
- Random m_axis_tready (50%) plus hdr_ready delayed 20 cycles -> byte stream identical to the no-stall reference. No s_axis_tready while in LEN.
- Preload row=0xFFFF by streaming 65535 single-beat lines, then one more line -> header row bytes 00 00 (wrap).
- Assert rst mid-payload -> all outputs 0 the next cycle and no descriptor. The next packet header shows scene=0, row=0, col=0.
